// File: rtl/pmod_debounce.sv
// pmod_debounce: two-channel synchroniser + debouncer for the PMOD operand
// pins of the 2-bit adder demo. Each channel accepts a new level only after
// DEBOUNCE_CYCLES consecutive stable synchronised samples. It then presents a
// clean registered level plus one-cycle rise/fall strobes.

module pmod_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned CNT_W           = 17
) (
    input  logic CLK,
    input  logic RST,
    input  logic PMOD1,
    input  logic PMOD2,
    output logic OUT1,
    output logic OUT2,
    output logic RISE1,
    output logic RISE2,
    output logic FALL1,
    output logic FALL2
);

    typedef enum logic [1:0] {
        LOW,
        RISE_WAIT,
        HIGH,
        FALL_WAIT
    } state_t;

    // Terminal count: the sample that completes DEBOUNCE_CYCLES stable samples
    // after the one that opened the wait state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] pins;
    assign pins = {PMOD2, PMOD1};

    for (genvar ch = 0; ch < 2; ch++) begin : chan
        logic             s1;
        logic             s;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             rise;
        logic             fall;

        // Two-flop synchroniser bringing the raw pin into the CLK domain.
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge value of its source; blocking here would collapse the
        // two synchroniser stages into one.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1 <= 1'b0;
                s  <= 1'b0;
            end else begin
                s1 <= pins[ch];
                s  <= s1;
            end
        end

        // Debounce FSM with registered level and single-cycle edge strobes.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state <= LOW;
                cnt   <= '0;
                level <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                // Strobes default low and are raised only on the accepting edge.
                rise <= 1'b0;
                fall <= 1'b0;
                case (state)
                    LOW: begin
                        if (s) begin
                            state <= RISE_WAIT;
                            cnt   <= '0;
                        end
                    end
                    RISE_WAIT: begin
                        if (!s) begin
                            state <= LOW;
                        end else if (cnt == CNT_LAST) begin
                            state <= HIGH;
                            level <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HIGH: begin
                        if (!s) begin
                            state <= FALL_WAIT;
                            cnt   <= '0;
                        end
                    end
                    FALL_WAIT: begin
                        if (s) begin
                            state <= HIGH;
                        end else if (cnt == CNT_LAST) begin
                            state <= LOW;
                            level <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= LOW;
                endcase
            end
        end
    end

    assign OUT1  = chan[0].level;
    assign OUT2  = chan[1].level;
    assign RISE1 = chan[0].rise;
    assign RISE2 = chan[1].rise;
    assign FALL1 = chan[0].fall;
    assign FALL2 = chan[1].fall;

endmodule

// File: tb/tb_pmod_debounce.sv
// Testbench for pmod_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
// The reference model accepts a new level once the last DEBOUNCE_CYCLES+1
// samples seen by the debouncer (the pin delayed by the synchroniser) all
// disagree with the current level.

module tb_pmod_debounce;

    localparam int D = 4;
    localparam int W = 3;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst;
    logic pmod1;
    logic pmod2;
    logic out1, out2, rise1, rise2, fall1, fall2;

    int    vectors    = 0;
    int    miscompares = 0;
    string phase      = "init";
    logic  seen_rise1;

    always #5 if (clk_en) clk = ~clk;

    pmod_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (W)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .PMOD1(pmod1),
        .PMOD2(pmod2),
        .OUT1 (out1),
        .OUT2 (out2),
        .RISE1(rise1),
        .RISE2(rise2),
        .FALL1(fall1),
        .FALL2(fall2)
    );

    // Reference model state, one entry per channel.
    logic       m_s1  [2];
    logic       m_s   [2];
    logic       m_out [2];
    logic       m_rise[2];
    logic       m_fall[2];
    logic [D:0] win   [2];
    int         nval  [2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c]   = 1'b0;
            m_s[c]    = 1'b0;
            m_out[c]  = 1'b0;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            win[c]    = '0;
            nval[c]   = 0;
        end
    endfunction

    function automatic void model_edge(input logic p1, input logic p2);
        logic pin [2];
        logic seen;
        pin[0] = p1;
        pin[1] = p2;
        for (int c = 0; c < 2; c++) begin
            seen      = m_s[c];
            m_s[c]    = m_s1[c];
            m_s1[c]   = pin[c];
            win[c]    = {win[c][D-1:0], seen};
            if (nval[c] < D + 1) nval[c]++;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (nval[c] == D + 1 && win[c] == {(D+1){~m_out[c]}}) begin
                m_out[c] = ~m_out[c];
                if (m_out[c]) m_rise[c] = 1'b1;
                else          m_fall[c] = 1'b1;
            end
        end
    endfunction

    task automatic cmp(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s/%s: observed %b expected %b", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        cmp("out1",  out1,  m_out[0]);
        cmp("out2",  out2,  m_out[1]);
        cmp("rise1", rise1, m_rise[0]);
        cmp("rise2", rise2, m_rise[1]);
        cmp("fall1", fall1, m_fall[0]);
        cmp("fall2", fall2, m_fall[1]);
        if (rise1 === 1'b1) seen_rise1 = 1'b1;
    endtask

    // One clock edge: advance the model with the pre-edge inputs, then check.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(pmod1, pmod2);
        #1;
        check_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [6];
        int   n_between;

        // Reset with inputs high and no clock running.
        phase      = "reset";
        seen_rise1 = 1'b0;
        rst   = 1'b0;
        pmod1 = 1'b1;
        pmod2 = 1'b1;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_all();
        #5 rst = 1'b0;
        #9 clk_en = 1'b1;
        repeat (6) tick();
        cmp("lat_out1_early", out1, 1'b0);
        tick();
        cmp("lat_out1",  out1,  1'b1);
        cmp("lat_out2",  out2,  1'b1);
        cmp("lat_rise1", rise1, 1'b1);
        cmp("lat_rise2", rise2, 1'b1);
        tick();
        cmp("lat_rise1_drop", rise1, 1'b0);
        cmp("lat_rise2_drop", rise2, 1'b0);

        // Release of channel 1.
        phase      = "release";
        seen_rise1 = 1'b0;
        pmod1      = 1'b0;
        repeat (6) tick();
        cmp("out1_held", out1, 1'b1);
        tick();
        cmp("out1_low", out1,  1'b0);
        cmp("fall1",    fall1, 1'b1);
        tick();
        cmp("fall1_drop",  fall1,      1'b0);
        cmp("no_rise1",    seen_rise1, 1'b0);
        pmod2 = 1'b0;
        repeat (8) tick();

        // Bounce rejection.
        phase      = "bounce";
        seen_rise1 = 1'b0;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            pmod1 = pat[i];
            tick();
        end
        pmod1 = 1'b0;
        repeat (8) tick();
        cmp("no_rise1", seen_rise1, 1'b0);
        cmp("out1_low", out1,       1'b0);

        // Independence: channel 2 rises two edges after channel 1.
        phase     = "indep";
        n_between = 0;
        pmod1     = 1'b1;
        tick();
        tick();
        pmod2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) cmp("rise1_at_e6", rise1, 1'b1);
            if (i == 6) cmp("rise2_at_e8", rise2, 1'b1);
            if (out1 === 1'b1 && out2 === 1'b0) n_between++;
        end
        cmp("gap_two_cycles", n_between == 2, 1'b1);
        pmod1 = 1'b0;
        pmod2 = 1'b0;
        repeat (8) tick();

        // Reset in the middle of a qualification.
        phase = "midreset";
        pmod2 = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        cmp("out2_not_yet", out2, 1'b0);
        tick();
        cmp("out2_full_latency", out2, 1'b1);
        pmod2 = 1'b0;
        repeat (8) tick();

        // Boundary pulse lengths on channel 1.
        phase = "pulse5";
        pmod1 = 1'b1;
        repeat (5) tick();
        pmod1 = 1'b0;
        tick();
        tick();
        cmp("out1_accepts", out1, 1'b1);
        repeat (10) tick();
        phase      = "pulse4";
        seen_rise1 = 1'b0;
        pmod1      = 1'b1;
        repeat (4) tick();
        pmod1 = 1'b0;
        repeat (10) tick();
        cmp("no_rise1", seen_rise1, 1'b0);
        cmp("out1_low", out1,       1'b0);

        // Randomised traffic with occasional asynchronous resets.
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) pmod1 = ~pmod1;
            if ($urandom_range(5) == 0) pmod2 = ~pmod2;
            if ($urandom_range(150) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_all();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
